// File: rtl/lcd_bus_if.sv
// LCD parallel bus between the page-display controller (master) and a display (slave).
`default_nettype none

interface lcd_bus_if;
  logic [7:0] lcd_data;
  logic       lcd_reset;   // RS: 0 = instruction, 1 = character data
  logic       lcd_enable;  // E strobe, falling edge captures the transfer

  modport master (output lcd_data, output lcd_reset, output lcd_enable);
  modport slave  (input  lcd_data, input  lcd_reset, input  lcd_enable);
endinterface

`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
// HD44780-style receiver: decodes LCD bus writes into a LINES x COLS character buffer
// with cursor, clear sweep and sticky error flags; buffer is readable on a side port.
`default_nettype none

module lcd_bus_receiver #(
  parameter int         COLS       = 16,
  parameter int         LINES      = 2,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  wire logic                              fpga_clk_i,
  input  wire logic                              fpga_reset_n_i,
  lcd_bus_if.slave                               lcd,
  input  wire logic [$clog2(LINES*COLS)-1:0]     rd_addr_i,
  output logic      [7:0]                        rd_data_o,
  output logic      [$clog2(LINES*COLS)-1:0]     cursor_o,
  output logic                                   busy_o,
  output logic                                   valid_o,
  output logic                                   overrun_o,
  output logic                                   bad_cmd_o
);

  localparam int COL_W  = $clog2(COLS);
  localparam int DEPTH  = LINES * COLS;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                en_q;
  logic [7:0]          mem [DEPTH];

  logic                fall;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [7:0]          wdata;
  logic [6:0]          ddram_a;
  logic                ddram_ok;
  logic [ADDR_W-1:0]   ddram_cursor;

  // DDRAM line 0 starts at 0x00, line 1 at 0x40; only the first COLS of each are backed.
  assign ddram_a      = lcd.lcd_data[6:0];
  assign ddram_ok     = ({1'b0, ddram_a[5:0]} < 7'(COLS));
  assign ddram_cursor = {ddram_a[6], ddram_a[COL_W-1:0]};

  always_comb begin
    fall  = en_q & ~lcd.lcd_enable;
    we    = 1'b0;
    waddr = cursor_o;
    wdata = lcd.lcd_data;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = BLANK_CHAR;
    end else if (fall && lcd.lcd_reset) begin
      we    = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge fpga_reset_n_i) begin
    if (!fpga_reset_n_i) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      cursor_o  <= '0;
      busy_o    <= 1'b1;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      bad_cmd_o <= 1'b0;
      rd_data_o <= 8'h00;
      en_q      <= 1'b0;
    end else begin
      en_q      <= lcd.lcd_enable;
      valid_o   <= 1'b0;
      rd_data_o <= mem[rd_addr_i];
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (fall) begin
            overrun_o <= 1'b1;
          end
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= S_IDLE;
            cursor_o <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b1;
          end
        end
        default: begin
          if (fall) begin
            if (lcd.lcd_reset) begin
              // Natural wrap of {line, col} gives line 0 -> line 1 -> line 0.
              cursor_o <= cursor_o + ADDR_W'(1);
              valid_o  <= 1'b1;
            end else begin
              case (lcd.lcd_data)
                8'h01: begin
                  state   <= S_CLEAR;
                  clr_cnt <= '0;
                  busy_o  <= 1'b1;
                end
                8'h02, 8'h03: begin
                  cursor_o <= '0;
                  valid_o  <= 1'b1;
                end
                8'h38, 8'h0C, 8'h06: begin
                  valid_o <= 1'b1;
                end
                default: begin
                  if (lcd.lcd_data[7] && ddram_ok) begin
                    cursor_o <= ddram_cursor;
                    valid_o  <= 1'b1;
                  end else begin
                    bad_cmd_o <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: behavioural model plus a scoreboard of expected valid pulses.
`default_nettype none

module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       busy, valid, overrun, bad_cmd;

  lcd_bus_if bus ();

  lcd_bus_receiver dut (
    .fpga_clk_i     (clk),
    .fpga_reset_n_i (rst_n),
    .lcd            (bus),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .cursor_o       (cursor),
    .busy_o         (busy),
    .valid_o        (valid),
    .overrun_o      (overrun),
    .bad_cmd_o      (bad_cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         at_cyc;
    logic [4:0] cur;
  } exp_t;
  exp_t q[$];

  int         tests = 0;
  int         fails = 0;
  logic [7:0] m_buf [32];
  logic [4:0] m_cur;
  logic       m_ovr, m_bad;
  int         m_clr_lo, m_clr_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every valid pulse must match the head of the scoreboard in cycle and cursor.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      chk("valid_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        chk("valid_cycle", cyc, q[0].at_cyc);
        chk("valid_cursor", 32'(cursor), 32'(q[0].cur));
        void'(q.pop_front());
      end
    end
  end

  task automatic push(input int at_cyc, input logic [4:0] cur);
    exp_t e;
    e.at_cyc = at_cyc;
    e.cur    = cur;
    q.push_back(e);
  endtask

  task automatic blank_model();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_cur = 5'd0;
  endtask

  // k is the cycle in which the falling edge of E is visible to the receiver.
  task automatic model(input int k, input logic r, input logic [7:0] d);
    logic [6:0] a;
    a = d[6:0];
    if (k >= m_clr_lo && k <= m_clr_hi) begin
      m_ovr = 1'b1;
    end else if (r) begin
      m_buf[m_cur] = d;
      m_cur = m_cur + 5'd1;
      push(k + 1, m_cur);
    end else if (d == 8'h01) begin
      m_clr_lo = k + 1;
      m_clr_hi = k + 32;
      blank_model();
      push(k + 33, 5'd0);
    end else if (d == 8'h02 || d == 8'h03) begin
      m_cur = 5'd0;
      push(k + 1, m_cur);
    end else if (d == 8'h38 || d == 8'h0C || d == 8'h06) begin
      push(k + 1, m_cur);
    end else if (d[7] && a <= 7'h0F) begin
      m_cur = a[4:0];
      push(k + 1, m_cur);
    end else if (d[7] && a >= 7'h40 && a <= 7'h4F) begin
      m_cur = 5'(16 + int'(a - 7'h40));
      push(k + 1, m_cur);
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic send(input logic r, input logic [7:0] d);
    @(posedge clk); #1;
    bus.lcd_data   = d;
    bus.lcd_reset  = r;
    bus.lcd_enable = 1'b1;
    @(posedge clk); #1;
    bus.lcd_enable = 1'b0;
    model(cyc, r, d);
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input int addr);
    @(posedge clk); #1;
    rd_addr = 5'(addr);
    @(posedge clk);
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(m_buf[addr]));
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 32; i++) rd_chk(tag, i);
  endtask

  task automatic release_and_sweep();
    int nbusy;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_clr_lo = cyc;
    m_clr_hi = cyc + 31;
    blank_model();
    push(cyc + 32, 5'd0);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    chk("busy_cycles", nbusy, 32);
  endtask

  task automatic chk_flags(input string tag);
    @(negedge clk);
    chk({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_bad_cmd"}, 32'(bad_cmd), 32'(m_bad));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_cursor"}, 32'(cursor), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_bad_cmd"}, 32'(bad_cmd), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cyc;
    bus.lcd_data   = 8'h00;
    bus.lcd_reset  = 1'b0;
    bus.lcd_enable = 1'b0;
    m_ovr = 1'b0;
    m_bad = 1'b0;
    m_clr_lo = -100;
    m_clr_hi = -100;
    blank_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values("reset");

    release_and_sweep();
    chk_all("init_blank");
    chk_flags("init");

    send(1'b0, 8'h80);
    send(1'b1, 8'h48);
    send(1'b1, 8'h45);
    send(1'b1, 8'h4C);
    send(1'b1, 8'h4C);
    send(1'b1, 8'h4F);
    for (int i = 0; i < 5; i++) rd_chk("hello_buf", i);
    chk_flags("hello");

    send(1'b0, 8'h8F);
    send(1'b1, 8'h41);
    send(1'b1, 8'h42);
    rd_chk("line0_end", 15);
    rd_chk("line1_start", 16);
    chk_flags("wrap_line");
    send(1'b0, 8'hCF);
    send(1'b1, 8'h43);
    send(1'b1, 8'h44);
    rd_chk("line1_end", 31);
    rd_chk("wrap_home", 0);
    chk_flags("wrap_full");

    send(1'b0, 8'h90);
    chk_flags("bad_ddram");
    send(1'b0, 8'hFF);
    chk_flags("bad_opcode");
    send(1'b0, 8'h38);
    chk_flags("noop_cmd");
    send(1'b0, 8'h02);
    chk_flags("home");
    rd_chk("home_keeps_buf", 1);

    send(1'b0, 8'h01);
    repeat (7) @(posedge clk);
    send(1'b1, 8'h5A);
    low_cyc = -1;
    for (int i = 0; i < 40 && low_cyc < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) low_cyc = cyc;
    end
    chk("clear_busy_low_cycle", low_cyc, m_clr_hi + 1);
    chk_flags("clear_overrun");
    chk_all("clear_blank");

    send(1'b1, 8'h54);
    send(1'b1, 8'h58);
    rd_chk("text_before_reset", 1);
    send(1'b0, 8'h01);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_bad = 1'b0;
    #1;
    chk_reset_values("mid_clear_reset");
    repeat (2) @(posedge clk);
    release_and_sweep();
    chk_all("post_reset_blank");
    chk_flags("post_reset");

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
